// File: rtl/operand_stage.sv
// Operand stage: decode-to-execute pipeline register with bypass resolution,
// load-use stall detection and a saturating bubble counter.
module operand_stage #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idValid,
  input  logic              idRegWrite,
  input  logic              idMemRead,
  input  logic [4:0]        idRn,
  input  logic [4:0]        idRm,
  input  logic [4:0]        idRd,
  output logic [4:0]        ReadRegister1,
  output logic [4:0]        ReadRegister2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [4:0]        exRd,
  input  logic              exRegWrite,
  input  logic              exMemRead,
  input  logic [DATA_W-1:0] exResult,
  input  logic [4:0]        memRd,
  input  logic              memRegWrite,
  input  logic [DATA_W-1:0] memResult,
  input  logic [4:0]        wbRd,
  input  logic              wbRegWrite,
  input  logic [DATA_W-1:0] wbData,
  input  logic              flush,
  input  logic              hold,
  output logic              stallID,
  output logic              oValid,
  output logic              oRegWrite,
  output logic              oMemRead,
  output logic [4:0]        oRd,
  output logic [DATA_W-1:0] oOpA,
  output logic [DATA_W-1:0] oOpB,
  output logic [15:0]       stallCount
);

  localparam logic [4:0] XZR = 5'd31;

  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic              loadUse;

  // A load still in EX cannot forward; its result is only available from MEM.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [4:0]        src,
    input logic [DATA_W-1:0] rdata,
    input logic [4:0]        eRd,
    input logic              eFwd,
    input logic [DATA_W-1:0] eData,
    input logic [4:0]        mRd,
    input logic              mWr,
    input logic [DATA_W-1:0] mData,
    input logic [4:0]        wRd,
    input logic              wWr,
    input logic [DATA_W-1:0] wData
  );
    if (src == XZR)
      return '0;
    else if (eFwd && (eRd == src))
      return eData;
    else if (mWr && (mRd == src))
      return mData;
    else if (wWr && (wRd == src))
      return wData;
    else
      return rdata;
  endfunction

  assign ReadRegister1 = idRn;
  assign ReadRegister2 = idRm;

  // Operand resolution and load-use hazard detection.
  always_comb begin
    opA = resolve(idRn, ReadData1, exRd, exRegWrite && !exMemRead, exResult,
                  memRd, memRegWrite, memResult, wbRd, wbRegWrite, wbData);
    opB = resolve(idRm, ReadData2, exRd, exRegWrite && !exMemRead, exResult,
                  memRd, memRegWrite, memResult, wbRd, wbRegWrite, wbData);
    loadUse = idValid && exRegWrite && exMemRead &&
              (((idRn == exRd) && (idRn != XZR)) ||
               ((idRm == exRd) && (idRm != XZR)));
    stallID = loadUse || hold;
  end

  // Output register update: reset, then hold, flush, load-use bubble, capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      oValid     <= 1'b0;
      oRegWrite  <= 1'b0;
      oMemRead   <= 1'b0;
      oRd        <= XZR;
      oOpA       <= '0;
      oOpB       <= '0;
      stallCount <= '0;
    end else if (!hold) begin
      if (flush) begin
        oValid    <= 1'b0;
        oRegWrite <= 1'b0;
        oMemRead  <= 1'b0;
      end else if (loadUse) begin
        oValid    <= 1'b0;
        oRegWrite <= 1'b0;
        oMemRead  <= 1'b0;
        if (stallCount != '1)
          stallCount <= stallCount + 16'd1;
      end else begin
        oValid    <= idValid;
        oRegWrite <= idRegWrite && idValid;
        oMemRead  <= idMemRead && idValid;
        oRd       <= idRd;
        oOpA      <= opA;
        oOpB      <= opB;
      end
    end
  end

endmodule
